// File: rtl/instr_loader.sv
// Instruction loader front end: synchronises and debounces three raw pins,
// assembles an INSTR_W-bit instruction MSB-first from shift strobes and
// issues a one-cycle btn_edge pulse on each debounced go press.

// Debounce one synchronised pin. The output flips only after the input
// has differed from it for CYCLES consecutive cycles.
module instr_loader_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic sync,
  output logic deb
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Count consecutive disagreeing cycles; flip deb on the last one.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync != deb) begin
      if (cnt == CW'(CYCLES - 1)) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end
endmodule

module instr_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int INSTR_W         = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ser_bit_raw,
  input  logic               shift_btn_raw,
  input  logic               go_btn_raw,
  input  logic               busy,
  output logic [3:0]         opcode,
  output logic [INSTR_W-5:0] instr,
  output logic               inst_done,
  output logic               btn_edge,
  output logic [4:0]         bit_count
);
  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOADING,
    S_READY
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(INSTR_W - 1);

  state_t             state, state_n;
  logic [2:0]         sync_s1, sync_s2;
  logic               ser_sync, shift_sync, go_sync;
  logic               deb_shift, deb_go, deb_shift_q, deb_go_q;
  logic               shift_rise, go_rise, shift_ok;
  logic               load_first, load_next;
  logic [INSTR_W-1:0] shift_reg;

  // Two-flop synchronisers for {ser, shift, go}.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= {ser_bit_raw, shift_btn_raw, go_btn_raw};
      sync_s2 <= sync_s1;
    end
  end

  assign {ser_sync, shift_sync, go_sync} = sync_s2;

  instr_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_shift (
    .clk  (clk),
    .rstn (rstn),
    .sync (shift_sync),
    .deb  (deb_shift)
  );

  instr_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_go (
    .clk  (clk),
    .rstn (rstn),
    .sync (go_sync),
    .deb  (deb_go)
  );

  // Delayed debounced values for rising-edge detection, plus the go pulse,
  // which is withheld while the downstream FSM is busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_shift_q <= 1'b0;
      deb_go_q    <= 1'b0;
      btn_edge    <= 1'b0;
    end else begin
      deb_shift_q <= deb_shift;
      deb_go_q    <= deb_go;
      btn_edge    <= go_rise & ~busy;
    end
  end

  assign shift_rise = deb_shift & ~deb_shift_q;
  assign go_rise    = deb_go & ~deb_go_q;
  assign shift_ok   = shift_rise & ~busy;

  // Loader state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_EMPTY;
    else       state <= state_n;
  end

  // Next state: each accepted shift advances; the INSTR_W-th bit lands in READY.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_n = state;
    unique case (state)
      S_EMPTY:   if (shift_ok) state_n = S_LOADING;
      S_LOADING: if (shift_ok && bit_count == LAST_BIT) state_n = S_READY;
      S_READY:   if (shift_ok) state_n = S_LOADING;
      default:   state_n = S_EMPTY;
    endcase
  end

  // Outputs decoded from state: valid flag and datapath load strobes.
  always_comb begin
    inst_done  = (state == S_READY);
    load_first = shift_ok && (state != S_LOADING);
    load_next  = shift_ok && (state == S_LOADING);
  end

  // Shift register and bit counter; a shift out of EMPTY/READY starts fresh.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (load_first) begin
      shift_reg <= {{(INSTR_W-1){1'b0}}, ser_sync};
      bit_count <= 5'd1;
    end else if (load_next) begin
      shift_reg <= {shift_reg[INSTR_W-2:0], ser_sync};
      bit_count <= bit_count + 5'd1;
    end
  end

  assign opcode = shift_reg[3:0];
  assign instr  = shift_reg[INSTR_W-1:4];
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with DEBOUNCE_CYCLES = 4, INSTR_W = 16.
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        rstn;
  logic        ser_bit_raw, shift_btn_raw, go_btn_raw, busy;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done, btn_edge;
  logic [4:0]  bit_count;

  int n_vec = 0;
  int n_err = 0;

  instr_loader #(.DEBOUNCE_CYCLES(4), .INSTR_W(16)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ser_bit_raw   (ser_bit_raw),
    .shift_btn_raw (shift_btn_raw),
    .go_btn_raw    (go_btn_raw),
    .busy          (busy),
    .opcode        (opcode),
    .instr         (instr),
    .inst_done     (inst_done),
    .btn_edge      (btn_edge),
    .bit_count     (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean shift press with the data pin settled beforehand.
  task automatic press_shift(input logic b);
    ser_bit_raw = b;
    repeat (3) tick();
    shift_btn_raw = 1'b1;
    repeat (10) tick();
    shift_btn_raw = 1'b0;
    repeat (10) tick();
  endtask

  task automatic load_bits(input logic [15:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) press_shift(v[i]);
  endtask

  initial begin
    int hits;
    int first;
    logic [15:0] word;

    rstn = 1'b0;
    ser_bit_raw = 1'b0;
    shift_btn_raw = 1'b0;
    go_btn_raw = 1'b0;
    busy = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    check("rst_bit_count", 32'(bit_count), 32'd0);
    check("rst_inst_done", 32'(inst_done), 32'd0);
    check("rst_btn_edge",  32'(btn_edge),  32'd0);
    check("rst_opcode",    32'(opcode),    32'd0);
    check("rst_instr",     32'(instr),     32'd0);

    // Load 0x1238 MSB-first, following the count bit by bit.
    word = 16'h1238;
    for (int i = 15; i >= 0; i--) begin
      press_shift(word[i]);
      check($sformatf("load_cnt_%0d", 16 - i), 32'(bit_count), 32'(16 - i));
      check($sformatf("load_done_%0d", 16 - i), 32'(inst_done), (i == 0) ? 32'd1 : 32'd0);
    end
    check("load_opcode", 32'(opcode), 32'h8);
    check("load_instr",  32'(instr),  32'h123);

    // A 3-cycle glitch on the shift pin is filtered out.
    shift_btn_raw = 1'b1;
    repeat (3) tick();
    shift_btn_raw = 1'b0;
    repeat (10) tick();
    check("glitch_cnt",  32'(bit_count), 32'd16);
    check("glitch_done", 32'(inst_done), 32'd1);

    // Held press: debounced after 2+4 edges, shift registers on the next one.
    ser_bit_raw = 1'b0;
    repeat (3) tick();
    shift_btn_raw = 1'b1;
    repeat (6) tick();
    check("timed_cnt_before", 32'(bit_count), 32'd16);
    tick();
    check("timed_cnt_after",  32'(bit_count), 32'd1);
    check("timed_done_after", 32'(inst_done), 32'd0);
    repeat (4) tick();
    shift_btn_raw = 1'b0;
    repeat (10) tick();

    // Go held 50 cycles: one pulse, 7 edges after the raw edge; release is silent.
    hits = 0;
    first = 0;
    go_btn_raw = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (btn_edge) begin
        hits++;
        if (first == 0) first = c;
      end
    end
    check("go_pulses",  32'(hits),  32'd1);
    check("go_latency", 32'(first), 32'd7);
    hits = 0;
    go_btn_raw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (btn_edge) hits++;
    end
    check("go_release_pulses", 32'(hits), 32'd0);
    check("go_keeps_count", 32'(bit_count), 32'd1);

    // Finish the word: leading 0 already in, remaining 15 bits of 0x7ABC.
    load_bits(16'h7ABC, 14, 0);
    check("w2_done",   32'(inst_done), 32'd1);
    check("w2_cnt",    32'(bit_count), 32'd16);
    check("w2_opcode", 32'(opcode),    32'hC);
    check("w2_instr",  32'(instr),     32'h7AB);

    // While busy, shift and go presses are both ignored.
    busy = 1'b1;
    ser_bit_raw = 1'b1;
    repeat (3) tick();
    hits = 0;
    shift_btn_raw = 1'b1;
    go_btn_raw = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (btn_edge) hits++;
    end
    shift_btn_raw = 1'b0;
    go_btn_raw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (btn_edge) hits++;
    end
    check("busy_pulses", 32'(hits),      32'd0);
    check("busy_cnt",    32'(bit_count), 32'd16);
    check("busy_done",   32'(inst_done), 32'd1);
    check("busy_opcode", 32'(opcode),    32'hC);
    check("busy_instr",  32'(instr),     32'h7AB);
    busy = 1'b0;
    press_shift(1'b1);
    check("unbusy_done", 32'(inst_done), 32'd0);
    check("unbusy_cnt",  32'(bit_count), 32'd1);

    // Eight more bits (9 total), then asynchronous reset mid-cycle.
    load_bits(16'h00A5, 7, 0);
    check("part_cnt",    32'(bit_count), 32'd9);
    check("part_opcode", 32'(opcode),    32'h5);
    #3;
    rstn = 1'b0;
    #1;
    check("arst_cnt",    32'(bit_count), 32'd0);
    check("arst_done",   32'(inst_done), 32'd0);
    check("arst_opcode", 32'(opcode),    32'd0);
    check("arst_instr",  32'(instr),     32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    load_bits(16'h0F05, 15, 0);
    check("w3_done",   32'(inst_done), 32'd1);
    check("w3_opcode", 32'(opcode),    32'h5);
    check("w3_instr",  32'(instr),     32'h0F0);

    // 16th shift and go debounced on the same cycle.
    word = 16'hA5C3;
    load_bits(word, 15, 1);
    check("sim_cnt15", 32'(bit_count), 32'd15);
    ser_bit_raw = word[0];
    repeat (3) tick();
    shift_btn_raw = 1'b1;
    go_btn_raw = 1'b1;
    repeat (6) tick();
    check("sim_done_before", 32'(inst_done), 32'd0);
    check("sim_edge_before", 32'(btn_edge),  32'd0);
    tick();
    check("sim_done",   32'(inst_done), 32'd1);
    check("sim_edge",   32'(btn_edge),  32'd1);
    check("sim_cnt",    32'(bit_count), 32'd16);
    check("sim_opcode", 32'(opcode),    32'h3);
    check("sim_instr",  32'(instr),     32'hA5C);
    tick();
    check("sim_edge_one_cycle", 32'(btn_edge), 32'd0);
    shift_btn_raw = 1'b0;
    go_btn_raw = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
